businterface_split: RTL and testbench
=====================================

BUSINTERFACE_SPLIT -- requirements
Module: businterface_split

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bus data width in bits; legal values 32 and 64; LANES = DATA_WIDTH/8, LB = log2(LANES).
REQ-002 Parameter TIMEOUT_CYCLES, default 15, maximum cycles a bus beat waits for bus_ack before a bus error.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_address  in  32  byte address of the access.
REQ-006 cpu_cycle_width  in  2  CW_BYTE / CW_WORD / CW_LONG, encodings from businterface.vh.
REQ-007 cpu_data_out  in  32  write data, right-justified.
REQ-008 cpu_data_in  out  32  read data, right-justified, zero-extended.
REQ-009 cpu_read, cpu_write  in  1 each  access request; held high until cpu_ready.
REQ-010 cpu_ready  out  1  one-cycle completion pulse.
REQ-011 cpu_bus_error  out  1  high together with cpu_ready when the access failed.
REQ-012 businterface_address  out  32-LB  beat address, bits [31:LB].
REQ-013 businterface_data_out  out  DATA_WIDTH  lane-steered write data.
REQ-014 businterface_data_in  in  DATA_WIDTH  read data from the bus.
REQ-015 businterface_data_strobes  out  LANES  byte-lane enables; MSB = lowest address (big-endian).
REQ-016 businterface_read, businterface_write  out  1 each  bus beat strobes.
REQ-017 businterface_ack  in  1  beat complete; sampled only while a strobe is high.

Function
- REQ-018 FSM states: IDLE, BEAT1, BEAT2, DONE. All outputs are registered.
- REQ-019 In IDLE, the block latches address, width, data and direction when cpu_read or cpu_write is high.
- REQ-020 If cpu_read and cpu_write are both high, the block goes straight to DONE with cpu_bus_error=1, and no bus strobe is raised.
- REQ-021 Byte lane for byte k of the access: lane = (cpu_address + k) mod LANES; byte 0 is the most significant byte of the access.
- REQ-022 The businterface_read/businterface_write strobe rises the cycle after the request is latched and stays high until the cycle after businterface_ack.
- REQ-023 Address, strobes and data_out are stable while a strobe is high.
- REQ-024 Unselected data_out lanes are driven with 0.
- REQ-025 Read data is captured on the ack edge; unselected lanes are discarded; cpu_data_in bits above the access width are 0.
- REQ-026 An access that crosses a LANES-byte boundary uses BEAT1 for the low-address part and BEAT2 at address+1 beat for the remainder; the read result is merged in order.
- REQ-027 DONE asserts cpu_ready for exactly one cycle, then the FSM returns to IDLE.
- REQ-028 The CPU drops its request in the cpu_ready cycle; a request still high at the next edge starts a new access.
- REQ-029 Latency: request at edge N, strobe from N+1; with ack at edge M, cpu_ready is high in cycle M+1. A zero-wait aligned access takes 3 cycles.
- REQ-030 Timeout: a per-beat counter resets on beat entry. If it reaches TIMEOUT_CYCLES without ack, the strobe drops, the FSM enters DONE with cpu_bus_error=1, and BEAT2 is skipped.
- REQ-031 An ack arriving on the same edge as timeout expiry counts as success.
- REQ-032 An address of 0xFFFFFFFF crossing into the next beat wraps to beat 0.
- REQ-033 businterface_ack while no strobe is high is ignored.

Reset
- REQ-034 At reset: FSM=IDLE, counter=0, and all outputs 0 (strobes, data_out, address, cpu_data_in, cpu_ready, cpu_bus_error).
- REQ-035 Reset mid-access abandons the beat immediately; no cpu_ready is produced for it.

Configuration
- REQ-036 BUSINTERFACE_MISALIGNED_SPLIT_EN defined: misaligned accesses are supported per REQ-021 and REQ-026.
- REQ-037 BUSINTERFACE_MISALIGNED_SPLIT_EN undefined: a word at an odd address, or a long at an address not divisible by 4, goes IDLE->DONE with cpu_bus_error=1 and no bus strobe. BEAT2 does not exist.

Verification
- REQ-038 DW=32, byte read @0x00000001, bus_data_in=0x12345678, ack on first strobe cycle -> strobes 0100, cpu_data_in=0x00000034, cpu_ready at cycle 3.
- REQ-039 DW=32, word write 0x0000abcd @0x00000002 -> data_out=0x0000abcd, strobes 0011, address bits [31:2]=0.
- REQ-040 DW=32, SPLIT_EN, long read @0x00000003, beats return 0x11223344 then 0x55667788 -> beat1 strobes 0001 @0, beat2 strobes 1110 @1, cpu_data_in=0x44556677.
- REQ-041 SPLIT_EN undefined, long read @0x00000002 -> cpu_ready with cpu_bus_error=1, no strobe ever high.
- REQ-042 TIMEOUT_CYCLES=4, no ack -> strobe high 4 cycles, then cpu_ready with cpu_bus_error=1.
- REQ-043 DW=64, byte write 0xab @0x00000005 -> strobes 00000100, data_out=0x0000000000ab0000; reset during that strobe -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/businterface_split_if.sv
// businterface_split shared encodings and bus-side bundle.
// master = bridge driving the bus, slave = bus target.
package businterface_split_pkg;
  localparam logic [1:0] CW_BYTE = 2'b00;
  localparam logic [1:0] CW_WORD = 2'b01;
  localparam logic [1:0] CW_LONG = 2'b10;
endpackage

interface businterface_split_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int LB    = $clog2(LANES);

  logic [31-LB:0]        address;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] data_in;
  logic [LANES-1:0]      data_strobes;
  logic                  read;
  logic                  write;
  logic                  ack;

  modport master (
    output address, data_out, data_strobes,
    output read, write,
    input  data_in, ack
  );

  modport slave (
    input  address, data_out, data_strobes,
    input  read, write,
    output data_in, ack
  );
endinterface

// File: rtl/businterface_split.sv
// businterface_split: CPU-to-bus bridge, big-endian byte-lane steering.
// Macro BUSINTERFACE_MISALIGNED_SPLIT_EN enables two-beat misaligned access.
module businterface_split
  import businterface_split_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic [1:0]  cpu_cycle_width,
  input  logic [31:0] cpu_data_out,
  output logic [31:0] cpu_data_in,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic        cpu_ready,
  output logic        cpu_bus_error,
  businterface_split_if.master businterface
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int LB    = $clog2(LANES);
  localparam int CNTW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW    = 32 - LB;

`ifdef BUSINTERFACE_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE, S_BEAT1, S_BEAT2, S_DONE
  } state_t;

  function automatic int nbytes(
    input logic [1:0] cw
  );
    int n;
    unique case (cw)
      CW_BYTE: n = 1;
      CW_WORD: n = 2;
      CW_LONG: n = 4;
      default: n = 0;
    endcase
    return n;
  endfunction

  function automatic int lane_off(
    input logic [31:0] a
  );
    return int'(a & 32'(LANES - 1));
  endfunction

  // hi selects the part of the access that spills into the next beat
  function automatic logic [LANES-1:0] beat_strb(
    input logic [31:0] a,
    input logic [1:0]  cw,
    input logic        hi
  );
    logic [LANES-1:0] s;
    int pos;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      pos = lane_off(a) + k;
      if (k < nbytes(cw) && ((pos >= LANES) == hi))
        s[LANES-1-(pos % LANES)] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] beat_wdata(
    input logic [31:0] a,
    input logic [1:0]  cw,
    input logic [31:0] d,
    input logic        hi
  );
    logic [DATA_WIDTH-1:0] w;
    int pos;
    int n;
    w = '0;
    n = nbytes(cw);
    for (int k = 0; k < 4; k++) begin
      pos = lane_off(a) + k;
      if (k < n && ((pos >= LANES) == hi))
        w[DATA_WIDTH-1-8*(pos % LANES) -: 8] = d[8*(n-1-k) +: 8];
    end
    return w;
  endfunction

  function automatic logic [31:0] beat_rdata(
    input logic [31:0]           a,
    input logic [1:0]            cw,
    input logic [DATA_WIDTH-1:0] bus,
    input logic                  hi
  );
    logic [31:0] r;
    int pos;
    int n;
    r = '0;
    n = nbytes(cw);
    for (int k = 0; k < 4; k++) begin
      pos = lane_off(a) + k;
      if (k < n && ((pos >= LANES) == hi))
        r[8*(n-1-k) +: 8] = bus[DATA_WIDTH-1-8*(pos % LANES) -: 8];
    end
    return r;
  endfunction

  function automatic logic need_split(
    input logic [31:0] a,
    input logic [1:0]  cw
  );
    return (lane_off(a) + nbytes(cw)) > LANES;
  endfunction

  function automatic logic misaligned(
    input logic [31:0] a,
    input logic [1:0]  cw
  );
    return ((cw == CW_WORD) && a[0]) ||
           ((cw == CW_LONG) && (a[1:0] != 2'b00));
  endfunction

  state_t state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, acc_q, acc_d;
  logic [1:0]  cw_q;
  logic        wr_q;

  logic req, start_err, split_q, expire, beat_q;
  logic idle, hi, to_beat, src_wr;
  logic [31:0] src_addr, src_data, merged, din_d;
  logic [1:0]  src_cw;
  logic read_d, write_d, ready_d, err_d;
  logic [AW-1:0] addr_d;
  logic [LANES-1:0] strb_d;
  logic [DATA_WIDTH-1:0] dout_d;

  assign req       = cpu_read | cpu_write;
  assign start_err = (cpu_read & cpu_write) |
                     (nbytes(cpu_cycle_width) == 0) |
                     (!SPLIT_EN &&
                      misaligned(cpu_address, cpu_cycle_width));
  assign split_q   = SPLIT_EN && need_split(addr_q, cw_q);
  assign expire    = cnt_q == CNTW'(TIMEOUT_CYCLES - 1);
  assign beat_q    = (state_q == S_BEAT1) || (state_q == S_BEAT2);

  // state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next state: ack wins over a timeout expiring on the same edge
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (req) state_d = start_err ? S_DONE : S_BEAT1;
      S_BEAT1:
        if (businterface.ack)
          state_d = split_q ? S_BEAT2 : S_DONE;
        else if (expire)
          state_d = S_DONE;
      S_BEAT2:
        if (businterface.ack || expire) state_d = S_DONE;
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // next values of the registered outputs and datapath
  always_comb begin
    idle     = state_q == S_IDLE;
    src_addr = idle ? cpu_address     : addr_q;
    src_cw   = idle ? cpu_cycle_width : cw_q;
    src_data = idle ? cpu_data_out    : wdata_q;
    src_wr   = idle ? cpu_write       : wr_q;
    hi       = state_d == S_BEAT2;
    to_beat  = (state_d == S_BEAT1) || hi;
    read_d   = to_beat & ~src_wr;
    write_d  = to_beat & src_wr;
    addr_d   = '0;
    strb_d   = '0;
    dout_d   = '0;
    if (to_beat) begin
      addr_d = src_addr[31:LB] + AW'(hi);
      strb_d = beat_strb(src_addr, src_cw, hi);
      if (src_wr)
        dout_d = beat_wdata(src_addr, src_cw, src_data, hi);
    end
    merged = acc_q | beat_rdata(addr_q, cw_q,
                                businterface.data_in,
                                state_q == S_BEAT2);
    ready_d = state_d == S_DONE;
    err_d   = ready_d && (idle || !businterface.ack);
    din_d   = cpu_data_in;
    if (ready_d)
      din_d = (beat_q && businterface.ack && !wr_q) ?
              merged : 32'h0;
    acc_d = acc_q;
    if (idle)
      acc_d = '0;
    else if (beat_q && businterface.ack)
      acc_d = merged;
    cnt_d = (beat_q && state_d == state_q) ?
            cnt_q + CNTW'(1) : '0;
  end

  // request latch, beat counter and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q                     <= '0;
      addr_q                    <= '0;
      wdata_q                   <= '0;
      cw_q                      <= '0;
      wr_q                      <= 1'b0;
      acc_q                     <= '0;
      cpu_data_in               <= '0;
      cpu_ready                 <= 1'b0;
      cpu_bus_error             <= 1'b0;
      businterface.read         <= 1'b0;
      businterface.write        <= 1'b0;
      businterface.address      <= '0;
      businterface.data_out     <= '0;
      businterface.data_strobes <= '0;
    end else begin
      if (idle && req) begin
        addr_q  <= cpu_address;
        wdata_q <= cpu_data_out;
        cw_q    <= cpu_cycle_width;
        wr_q    <= cpu_write;
      end
      cnt_q                     <= cnt_d;
      acc_q                     <= acc_d;
      cpu_data_in               <= din_d;
      cpu_ready                 <= ready_d;
      cpu_bus_error             <= err_d;
      businterface.read         <= read_d;
      businterface.write        <= write_d;
      businterface.address      <= addr_d;
      businterface.data_out     <= dout_d;
      businterface.data_strobes <= strb_d;
    end
  end

endmodule

// File: tb/tb_businterface_split.sv
// Scoreboard bench for businterface_split.
// dut_a: 32-bit bus, 4-cycle timeout; dut_b: 64-bit bus.
`timescale 1ns/1ps
module tb_businterface_split;
  import businterface_split_pkg::*;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  strb;
    logic [63:0] dout;
    int          delay;
    logic [63:0] rdata;
  } beat_t;

  typedef struct {
    logic        err;
    logic        chkd;
    logic [31:0] data;
    int          lat;
    int          sc;
  } done_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] a_addr = '0, a_dout = '0, a_din;
  logic [1:0]  a_cw = '0;
  logic        a_rd = 1'b0, a_wr = 1'b0, a_ready, a_err;
  logic [31:0] b_addr = '0, b_dout = '0, b_din;
  logic [1:0]  b_cw = '0;
  logic        b_rd = 1'b0, b_wr = 1'b0, b_ready, b_err;

  businterface_split_if #(.DATA_WIDTH(32)) bus_a ();
  businterface_split_if #(.DATA_WIDTH(64)) bus_b ();

  businterface_split #(
    .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) dut_a (
    .clock(clock), .reset(reset),
    .cpu_address(a_addr), .cpu_cycle_width(a_cw),
    .cpu_data_out(a_dout), .cpu_data_in(a_din),
    .cpu_read(a_rd), .cpu_write(a_wr),
    .cpu_ready(a_ready), .cpu_bus_error(a_err),
    .businterface(bus_a)
  );

  businterface_split #(
    .DATA_WIDTH(64), .TIMEOUT_CYCLES(15)
  ) dut_b (
    .clock(clock), .reset(reset),
    .cpu_address(b_addr), .cpu_cycle_width(b_cw),
    .cpu_data_out(b_dout), .cpu_data_in(b_din),
    .cpu_read(b_rd), .cpu_write(b_wr),
    .cpu_ready(b_ready), .cpu_bus_error(b_err),
    .businterface(bus_b)
  );

  function automatic void chk(input string name,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  beat_t qa[$], qb[$];
  done_t da[$], db[$];
  beat_t ea, eb;
  done_t fa, fb;
  logic ack_en_a = 1'b1, ack_en_b = 1'b1;
  int wa = 0, la = 0, sa = 0;
  int wb = 0, lb = 0, sb = 0;

  // responder + monitor for dut_a
  always @(negedge clock) begin
    if (reset) begin
      bus_a.ack = 1'b0; bus_a.data_in = '0;
      wa = 0; la = 0; sa = 0;
    end else begin
      if (a_rd || a_wr || a_ready) la++;
      if (bus_a.read || bus_a.write) begin
        sa++;
        bus_a.ack = 1'b0;
        if (ack_en_a && qa.size() > 0 && wa == qa[0].delay) begin
          ea = qa.pop_front();
          bus_a.ack = 1'b1;
          bus_a.data_in = ea.rdata[31:0];
          wa = 0;
          chk("a_dir", 64'({bus_a.read, bus_a.write}),
              64'({ea.rd, ea.wr}));
          chk("a_addr", 64'(bus_a.address), 64'(ea.addr));
          chk("a_strb", 64'(bus_a.data_strobes), 64'(ea.strb));
          if (ea.wr)
            chk("a_dout", 64'(bus_a.data_out), ea.dout);
        end else wa++;
      end else begin
        bus_a.ack = 1'b1;
        bus_a.data_in = 32'hdeadbeef;
        wa = 0;
      end
      if (a_ready) begin
        chk("a_ready_expected", 64'(da.size() > 0), 64'd1);
        if (da.size() > 0) begin
          fa = da.pop_front();
          chk("a_bus_error", 64'(a_err), 64'(fa.err));
          if (fa.chkd)
            chk("a_data_in", 64'(a_din), 64'(fa.data));
          chk("a_latency", 64'(la), 64'(fa.lat));
          chk("a_strobe_cycles", 64'(sa), 64'(fa.sc));
        end
        la = 0; sa = 0;
      end
    end
  end

  // responder + monitor for dut_b
  always @(negedge clock) begin
    if (reset) begin
      bus_b.ack = 1'b0; bus_b.data_in = '0;
      wb = 0; lb = 0; sb = 0;
    end else begin
      if (b_rd || b_wr || b_ready) lb++;
      if (bus_b.read || bus_b.write) begin
        sb++;
        bus_b.ack = 1'b0;
        if (ack_en_b && qb.size() > 0 && wb == qb[0].delay) begin
          eb = qb.pop_front();
          bus_b.ack = 1'b1;
          bus_b.data_in = eb.rdata;
          wb = 0;
          chk("b_dir", 64'({bus_b.read, bus_b.write}),
              64'({eb.rd, eb.wr}));
          chk("b_addr", 64'(bus_b.address), 64'(eb.addr));
          chk("b_strb", 64'(bus_b.data_strobes), 64'(eb.strb));
          if (eb.wr) chk("b_dout", bus_b.data_out, eb.dout);
        end else wb++;
      end else begin
        bus_b.ack = 1'b1;
        bus_b.data_in = 64'hdeadbeef_deadbeef;
        wb = 0;
      end
      if (b_ready) begin
        chk("b_ready_expected", 64'(db.size() > 0), 64'd1);
        if (db.size() > 0) begin
          fb = db.pop_front();
          chk("b_bus_error", 64'(b_err), 64'(fb.err));
          if (fb.chkd)
            chk("b_data_in", 64'(b_din), 64'(fb.data));
          chk("b_latency", 64'(lb), 64'(fb.lat));
          chk("b_strobe_cycles", 64'(sb), 64'(fb.sc));
        end
        lb = 0; sb = 0;
      end
    end
  end

  task automatic beat_a(input logic rd, input logic wr,
                        input logic [31:0] addr,
                        input logic [7:0] strb,
                        input logic [63:0] dout,
                        input int delay,
                        input logic [63:0] rdata);
    beat_t b;
    b.rd = rd; b.wr = wr; b.addr = addr; b.strb = strb;
    b.dout = dout; b.delay = delay; b.rdata = rdata;
    qa.push_back(b);
  endtask

  task automatic done_a(input logic err, input logic chkd,
                        input logic [31:0] data,
                        input int lat, input int sc);
    done_t d;
    d.err = err; d.chkd = chkd; d.data = data;
    d.lat = lat; d.sc = sc;
    da.push_back(d);
  endtask

  task automatic access_a(input logic rd, input logic wr,
                          input logic [31:0] addr,
                          input logic [1:0] cw,
                          input logic [31:0] d);
    @(posedge clock); #1;
    a_rd = rd; a_wr = wr; a_addr = addr; a_cw = cw; a_dout = d;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (a_ready) break;
    end
    chk("a_ready_seen", 64'(a_ready), 64'd1);
    a_rd = 1'b0; a_wr = 1'b0;
  endtask

  task automatic access_b(input logic rd, input logic wr,
                          input logic [31:0] addr,
                          input logic [1:0] cw,
                          input logic [31:0] d);
    @(posedge clock); #1;
    b_rd = rd; b_wr = wr; b_addr = addr; b_cw = cw; b_dout = d;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (b_ready) break;
    end
    chk("b_ready_seen", 64'(b_ready), 64'd1);
    b_rd = 1'b0; b_wr = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_cpu"}, 64'({a_ready, a_err, a_din}), 64'd0);
    chk({tag, "_a_bus"}, 64'({bus_a.read, bus_a.write,
        bus_a.data_strobes, bus_a.address}), 64'd0);
    chk({tag, "_a_dout"}, 64'(bus_a.data_out), 64'd0);
    chk({tag, "_b_cpu"}, 64'({b_ready, b_err, b_din}), 64'd0);
    chk({tag, "_b_bus"}, 64'({bus_b.read, bus_b.write,
        bus_b.data_strobes, bus_b.address}), 64'd0);
    chk({tag, "_b_dout"}, bus_b.data_out, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int stray;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // byte read @1 -> lane 1
    beat_a(1, 0, 32'h0, 8'b0100, 0, 0, 64'h12345678);
    done_a(0, 1, 32'h34, 3, 1);
    access_a(1, 0, 32'h1, CW_BYTE, 32'h0);

    // word write @2 -> lanes 2,3
    beat_a(0, 1, 32'h0, 8'b0011, 64'h0000abcd, 0, 0);
    done_a(0, 0, 32'h0, 3, 1);
    access_a(0, 1, 32'h2, CW_WORD, 32'h0000abcd);

    // aligned long read with two wait states
    beat_a(1, 0, 32'h40, 8'b1111, 0, 2, 64'hcafef00d);
    done_a(0, 1, 32'hcafef00d, 5, 3);
    access_a(1, 0, 32'h100, CW_LONG, 32'h0);

    // word read @0 with one wait state
    beat_a(1, 0, 32'h0, 8'b1100, 0, 1, 64'h89abcdef);
    done_a(0, 1, 32'h000089ab, 4, 2);
    access_a(1, 0, 32'h0, CW_WORD, 32'h0);

    // read and write together -> immediate error
    done_a(1, 0, 32'h0, 2, 0);
    access_a(1, 1, 32'h10, CW_LONG, 32'h55);

`ifdef BUSINTERFACE_MISALIGNED_SPLIT_EN
    // word @1 stays inside one beat
    beat_a(1, 0, 32'h0, 8'b0110, 0, 0, 64'h00aabb00);
    done_a(0, 1, 32'h0000aabb, 3, 1);
    access_a(1, 0, 32'h1, CW_WORD, 32'h0);
    // long @3 splits 1 + 3
    beat_a(1, 0, 32'h0, 8'b0001, 0, 0, 64'h11223344);
    beat_a(1, 0, 32'h1, 8'b1110, 0, 0, 64'h55667788);
    done_a(0, 1, 32'h44556677, 4, 2);
    access_a(1, 0, 32'h3, CW_LONG, 32'h0);
    // long @2 splits 2 + 2, second beat waits one cycle
    beat_a(1, 0, 32'h0, 8'b0011, 0, 0, 64'haabbccdd);
    beat_a(1, 0, 32'h1, 8'b1100, 0, 1, 64'h11223344);
    done_a(0, 1, 32'hccdd1122, 5, 3);
    access_a(1, 0, 32'h2, CW_LONG, 32'h0);
    // word write @0xFFFFFFFF wraps to beat 0
    beat_a(0, 1, 32'h3fffffff, 8'b0001, 64'h00000012, 0, 0);
    beat_a(0, 1, 32'h0, 8'b1000, 64'h34000000, 0, 0);
    done_a(0, 0, 32'h0, 4, 2);
    access_a(0, 1, 32'hffffffff, CW_WORD, 32'h1234);
`else
    done_a(1, 0, 32'h0, 2, 0);
    access_a(1, 0, 32'h1, CW_WORD, 32'h0);
    done_a(1, 0, 32'h0, 2, 0);
    access_a(1, 0, 32'h3, CW_LONG, 32'h0);
    done_a(1, 0, 32'h0, 2, 0);
    access_a(1, 0, 32'h2, CW_LONG, 32'h0);
    done_a(1, 0, 32'h0, 2, 0);
    access_a(0, 1, 32'hffffffff, CW_WORD, 32'h1234);
`endif

    // no ack: four strobe cycles then error
    ack_en_a = 1'b0;
    done_a(1, 0, 32'h0, 6, 4);
    access_a(0, 1, 32'h0, CW_BYTE, 32'h77);
    ack_en_a = 1'b1;

    // ack on the expiry edge counts as success
    beat_a(1, 0, 32'h0, 8'b0001, 0, 3, 64'h000000ef);
    done_a(1'b0, 1, 32'h000000ef, 6, 4);
    access_a(1, 0, 32'h3, CW_BYTE, 32'h0);

    // 64-bit bus: byte write @5
    qb.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'h0,
                   strb: 8'b00000100,
                   dout: 64'h0000000000ab0000,
                   delay: 0, rdata: 64'h0});
    db.push_back('{err: 1'b0, chkd: 1'b0, data: 32'h0,
                   lat: 3, sc: 1});
    access_b(0, 1, 32'h5, CW_BYTE, 32'h000000ab);

    // same write, reset while the strobe is high
    ack_en_b = 1'b0;
    @(posedge clock); #1;
    b_wr = 1'b1; b_addr = 32'h5; b_cw = CW_BYTE;
    b_dout = 32'h000000ab;
    @(posedge clock); #1;
    chk("b_mid_write", 64'(bus_b.write), 64'd1);
    chk("b_mid_strb", 64'(bus_b.data_strobes), 64'h04);
    chk("b_mid_dout", bus_b.data_out, 64'h0000000000ab0000);
    reset = 1'b1;
    b_wr = 1'b0;
    @(posedge clock); #1;
    check_zero("midreset");
    reset = 1'b0;
    ack_en_b = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (b_ready || bus_b.write) stray++;
    end
    chk("b_quiet_after_reset", 64'(stray), 64'd0);

    repeat (3) @(posedge clock);
    #1;
    chk("a_beats_left", 64'(qa.size()), 64'd0);
    chk("a_dones_left", 64'(da.size()), 64'd0);
    chk("b_beats_left", 64'(qb.size()), 64'd0);
    chk("b_dones_left", 64'(db.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
